// File: rtl/bram_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared BRAM port.
// The slave modport is the arbiter's view; the master modport is the requester/BRAM side.
interface bram_port_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  rvalid0;
    logic                  rvalid1;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_q;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_q,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output mem_addr, mem_data, mem_we
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_q,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  mem_addr, mem_data, mem_we
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter with bounded hold sharing one synchronous BRAM port between
// the CPU load/store unit (r0) and the display fetch engine (r1).
module bram_port_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_HOLD   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    bram_port_arbiter_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_e;

    localparam logic [2:0] MAX_HOLD_C = 3'(MAX_HOLD);

    state_e                state_q;
    state_e                state_d;
    logic                  last_q;
    logic                  last_d;
    logic [2:0]            hold_q;
    logic [2:0]            hold_d;
    logic                  rvalid0_q;
    logic                  rvalid0_d;
    logic                  rvalid1_q;
    logic                  rvalid1_d;
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q;
    logic [DATA_WIDTH-1:0] rdata1_d;

    logic                  req0_s;
    logic                  req1_s;
    logic                  gnt0_s;
    logic                  gnt1_s;
    logic                  mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic [DATA_WIDTH-1:0] mem_data_s;

    function automatic logic [2:0] sat_inc(input logic [2:0] cnt);
        sat_inc = (cnt == 3'd7) ? cnt : (cnt + 3'd1);
    endfunction

    // Grant decision and next-state/owner bookkeeping.
    always_comb begin
        gnt0_s  = 1'b0;
        gnt1_s  = 1'b0;
        state_d = ST_IDLE;
        last_d  = last_q;
        hold_d  = 3'd0;
        // Reset is folded in here so no grant can leak out while it is asserted.
        req0_s  = bus.req0 & reset;
        req1_s  = bus.req1 & reset;

        if (req0_s && !req1_s) begin
            gnt0_s = 1'b1;
        end else if (req1_s && !req0_s) begin
            gnt1_s = 1'b1;
        end else if (req0_s && req1_s) begin
            case (state_q)
                ST_OWN0: begin
                    if (hold_q < MAX_HOLD_C) begin
                        gnt0_s = 1'b1;
                    end else begin
                        gnt1_s = 1'b1;
                    end
                end
                ST_OWN1: begin
                    if (hold_q < MAX_HOLD_C) begin
                        gnt1_s = 1'b1;
                    end else begin
                        gnt0_s = 1'b1;
                    end
                end
                default: begin
                    if (last_q) begin
                        gnt0_s = 1'b1;
                    end else begin
                        gnt1_s = 1'b1;
                    end
                end
            endcase
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end

        if (gnt0_s) begin
            state_d = ST_OWN0;
            last_d  = 1'b0;
            hold_d  = (state_q == ST_OWN0) ? sat_inc(hold_q) : 3'd1;
        end else if (gnt1_s) begin
            state_d = ST_OWN1;
            last_d  = 1'b1;
            hold_d  = (state_q == ST_OWN1) ? sat_inc(hold_q) : 3'd1;
        end else begin
            state_d = ST_IDLE;
            hold_d  = 3'd0;
        end
    end

    // BRAM port mux: fields of the granted requester, zeros when idle.
    always_comb begin
        mem_we_s   = 1'b0;
        mem_addr_s = {ADDR_WIDTH{1'b0}};
        mem_data_s = {DATA_WIDTH{1'b0}};
        if (gnt0_s) begin
            mem_we_s   = bus.we0;
            mem_addr_s = bus.addr0;
            mem_data_s = bus.wdata0;
        end else if (gnt1_s) begin
            mem_we_s   = bus.we1;
            mem_addr_s = bus.addr1;
            mem_data_s = bus.wdata1;
        end else begin
            mem_we_s   = 1'b0;
            mem_addr_s = {ADDR_WIDTH{1'b0}};
            mem_data_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Read-return tagging; the BRAM's q is only valid in the cycle after the commit,
    // so rdata passes mem_q through while rvalid is high and holds a captured copy after.
    always_comb begin
        rvalid0_d = gnt0_s & ~bus.we0;
        rvalid1_d = gnt1_s & ~bus.we1;
        if (rvalid0_q) begin
            rdata0_d = bus.mem_q;
        end else begin
            rdata0_d = rdata0_q;
        end
        if (rvalid1_q) begin
            rdata1_d = bus.mem_q;
        end else begin
            rdata1_d = rdata1_q;
        end
    end

    // Arbiter state, hold counter and read-return registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'b1;
            hold_q    <= 3'd0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= {DATA_WIDTH{1'b0}};
            rdata1_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign bus.gnt0     = gnt0_s;
    assign bus.gnt1     = gnt1_s;
    assign bus.mem_we   = mem_we_s;
    assign bus.mem_addr = mem_addr_s;
    assign bus.mem_data = mem_data_s;
    assign bus.rvalid0  = rvalid0_q;
    assign bus.rvalid1  = rvalid1_q;
    assign bus.rdata0   = rdata0_d;
    assign bus.rdata1   = rdata1_d;

endmodule
